// File: rtl/cpu_ppu_bridge_if.sv
// cpu_ppu_bridge_if: signal bundle between the CPU core, PPU register block and work RAM
// Ports: none (parameter RAM_AW sets the work-RAM address width)
// master: bridge side (drives CPU read return, PPU register access, RAM port)
// slave : environment side (CPU core, PPU, work RAM)
interface cpu_ppu_bridge_if #(parameter int RAM_AW = 11);
    logic              cpu_clk_en;
    logic [15:0]       cpu_addr;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_ready;
    logic [3:0]        reg_sel;
    logic              reg_en;
    logic              reg_rw;
    logic [7:0]        reg_data_in;
    logic [7:0]        reg_data_out;
    logic              cpu_sus;
    logic [15:0]       dma_addr;
    logic              dma_re;
    logic [7:0]        dma_rd_data;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wr_data;
    logic [7:0]        ram_rd_data;
    modport master (
        input  cpu_clk_en, cpu_addr, cpu_rd, cpu_wr, cpu_wdata, reg_data_out,
               cpu_sus, dma_addr, dma_re, ram_rd_data,
        output cpu_rdata, cpu_rvalid, cpu_ready, reg_sel, reg_en, reg_rw,
               reg_data_in, dma_rd_data, ram_addr, ram_we, ram_wr_data
    );
    modport slave (
        output cpu_clk_en, cpu_addr, cpu_rd, cpu_wr, cpu_wdata, reg_data_out,
               cpu_sus, dma_addr, dma_re, ram_rd_data,
        input  cpu_rdata, cpu_rvalid, cpu_ready, reg_sel, reg_en, reg_rw,
               reg_data_in, dma_rd_data, ram_addr, ram_we, ram_wr_data
    );
endinterface

// File: rtl/cpu_ppu_bridge.sv
// cpu_ppu_bridge: decodes 6502 bus accesses into PPU register / work-RAM accesses and returns read data
// Ports:
//   clk   - system clock
//   rst_n - synchronous reset, active low
//   bus   - cpu_ppu_bridge_if.master: CPU bus, PPU register port, OAMDMA read port, work-RAM port
// reg_sel encoding: 0..7 = PPUCTRL..PPUDATA (cpu_addr[2:0]), 8 = OAMDMA
module cpu_ppu_bridge #(
    parameter int RAM_AW = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_ppu_bridge_if.master bus
);
    typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_PPU, SRC_OPEN} src_t;
    localparam logic [3:0] SEL_OAMDMA = 4'd8;
    src_t       r_pend;
    src_t       w_pend_nxt;
    logic [7:0] r_open;
    logic [7:0] w_rdata;
    logic       w_rvalid;
    logic       w_valid;
    logic       w_en;
    logic       w_ram;
    logic       w_oamdma;
    logic       w_ppu;
    always_comb begin
        w_valid    = (bus.cpu_rd ^ bus.cpu_wr) && !bus.cpu_sus;
        w_en       = w_valid && bus.cpu_clk_en;
        w_ram      = bus.cpu_addr[15:13] == 3'b000;
        w_oamdma   = bus.cpu_addr == 16'h4014;
        w_ppu      = bus.cpu_addr[15:13] == 3'b001 || w_oamdma;
        w_pend_nxt = !(w_valid && bus.cpu_rd) ? SRC_NONE :
                     w_ram ? SRC_RAM : w_ppu ? SRC_PPU : SRC_OPEN;
        // RAM data is the synchronous result of last cycle's address, so it lines up with r_pend
        w_rvalid   = r_pend != SRC_NONE;
        w_rdata    = r_pend == SRC_RAM ? bus.ram_rd_data :
                     r_pend == SRC_PPU ? bus.reg_data_out :
                     r_pend == SRC_OPEN ? r_open : 8'h00;
    end
    assign bus.cpu_ready   = !bus.cpu_sus;
    assign bus.cpu_rdata   = w_rdata;
    assign bus.cpu_rvalid  = w_rvalid;
    assign bus.reg_sel     = w_oamdma ? SEL_OAMDMA : {1'b0, bus.cpu_addr[2:0]};
    assign bus.reg_en      = w_en && w_ppu;
    assign bus.reg_rw      = bus.cpu_wr;
    assign bus.reg_data_in = (w_en && w_ppu) ? bus.cpu_wdata : 8'h00;
    // OAMDMA owns the RAM read port for as long as the CPU is suspended
    assign bus.ram_addr    = bus.cpu_sus ? bus.dma_addr[RAM_AW-1:0] : bus.cpu_addr[RAM_AW-1:0];
    assign bus.ram_we      = w_en && w_ram && bus.cpu_wr;
    assign bus.ram_wr_data = bus.cpu_wdata;
    assign bus.dma_rd_data = bus.ram_rd_data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= SRC_NONE;
            r_open <= 8'h00;
        end else if (bus.cpu_clk_en) begin
            r_pend <= w_pend_nxt;
            // a CPU write drives the bus this cycle, so it takes precedence over a returning read
            if (w_valid && bus.cpu_wr)
                r_open <= bus.cpu_wdata;
            else if (w_rvalid)
                r_open <= w_rdata;
        end
    end
endmodule
